// File: rtl/conv_1st_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_1st_sched_if : scheduler <-> datapath / downstream signal bundle       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface conv_1st_sched_if #(
  parameter int N_PIX = 40,
  parameter int DW    = 8
);
  logic                  start_i;
  logic [5:0]            num_ch_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic                  conv_sta_o;
  logic                  conv_valid_i;
  logic [N_PIX*DW-1:0]   conv_data_i;
  logic [DW-1:0]         out_data_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [4:0]            out_ch_o;
  logic [5:0]            out_idx_o;
  logic                  out_last_o;

  // Scheduler side
  modport slave (
    input  start_i, num_ch_i, conv_valid_i, conv_data_i, out_ready_i,
    output busy_o, done_o, err_o, conv_sta_o,
    output out_data_o, out_valid_o, out_ch_o, out_idx_o, out_last_o
  );

  // Controller / datapath / sink side
  modport master (
    output start_i, num_ch_i, conv_valid_i, conv_data_i, out_ready_i,
    input  busy_o, done_o, err_o, conv_sta_o,
    input  out_data_o, out_valid_o, out_ch_o, out_idx_o, out_last_o
  );
endinterface
`default_nettype wire

// File: rtl/conv_1st_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_1st_sched : ping-pong row scheduler between conv datapath and stream  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv_1st_sched #(
  parameter int N_PIX = 40,
  parameter int DW    = 8
) (
  input wire              clk,
  input wire              rst,
  conv_1st_sched_if.slave bus
);

  localparam int         ROW_W    = N_PIX * DW;
  localparam logic [5:0] IDX_LAST = 6'(N_PIX - 1);
  localparam logic [5:0] MAX_CH   = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [5:0]        num_ch_q,   num_ch_d;
  logic [5:0]        issued_q,   issued_d;
  logic [5:0]        drained_q,  drained_d;
  logic              outst_q,    outst_d;
  logic [1:0]        full_q,     full_d;
  logic              wr_ptr_q,   wr_ptr_d;
  logic              rd_ptr_q,   rd_ptr_d;
  logic [5:0]        idx_q,      idx_d;
  logic [4:0]        ch_q,       ch_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q,      err_d;
  logic [ROW_W-1:0]  buf_q [2];
  logic [ROW_W-1:0]  buf_d [2];

  logic              sta;
  logic              cap;
  logic              take;
  logic              row_done;
  logic [ROW_W-1:0]  rd_row;

  // Only one request in flight; the free-buffer test guarantees the buffer at
  // wr_ptr is empty when the row comes back.
  assign sta      = (state_q == S_RUN) && !outst_q && (full_q != 2'b11) &&
                    (issued_q < num_ch_q);
  assign cap      = (state_q == S_RUN) && bus.conv_valid_i && outst_q;
  assign take     = out_valid_q && bus.out_ready_i;
  assign row_done = take && (idx_q == IDX_LAST);
  assign rd_row   = buf_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    num_ch_d    = num_ch_q;
    issued_d    = issued_q;
    drained_d   = drained_q;
    outst_d     = outst_q;
    full_d      = full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    err_d       = err_q;
    buf_d       = buf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d   = S_RUN;
          num_ch_d  = (bus.num_ch_i == 6'd0 || bus.num_ch_i > MAX_CH) ?
                      MAX_CH : bus.num_ch_i;
          issued_d  = 6'd0;
          drained_d = 6'd0;
          outst_d   = 1'b0;
          full_d    = 2'b00;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
          idx_d     = 6'd0;
          ch_d      = 5'd0;
          err_d     = 1'b0;
        end
      end

      S_RUN: begin
        if (sta) begin
          outst_d  = 1'b1;
          issued_d = issued_q + 6'd1;
        end
        if (cap) begin
          buf_d[wr_ptr_q]  = bus.conv_data_i;
          full_d[wr_ptr_q] = 1'b1;
          wr_ptr_d         = ~wr_ptr_q;
          outst_d          = 1'b0;
        end
        if (take) begin
          if (row_done) begin
            idx_d            = 6'd0;
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            drained_d        = drained_q + 6'd1;
            // Hold the channel on the final row so it never runs past num_ch.
            if (drained_d != num_ch_q) begin
              ch_d = ch_q + 5'd1;
            end
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        if (drained_d == num_ch_q) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A row with no matching request is dropped; flagging wins over a
    // same-cycle start clear.
    if (bus.conv_valid_i && !cap) begin
      err_d = 1'b1;
    end

    // Looking at next-cycle flags lets a freed and a captured buffer swap
    // without a gap in out_valid.
    out_valid_d = full_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_ch_q    <= 6'd0;
      issued_q    <= 6'd0;
      drained_q   <= 6'd0;
      outst_q     <= 1'b0;
      full_q      <= 2'b00;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      idx_q       <= 6'd0;
      ch_q        <= 5'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_ch_q    <= num_ch_d;
      issued_q    <= issued_d;
      drained_q   <= drained_d;
      outst_q     <= outst_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Row storage carries no reset; its contents are only observed behind full flags.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_FIN);
  assign bus.err_o       = err_q;
  assign bus.conv_sta_o  = sta;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_valid_q ? rd_row[int'(idx_q) * DW +: DW] : '0;
  assign bus.out_ch_o    = ch_q;
  assign bus.out_idx_o   = idx_q;
  assign bus.out_last_o  = out_valid_q && (idx_q == IDX_LAST);

endmodule
`default_nettype wire

// File: tb/tb_conv_1st_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_1st_sched : randomized bench with row-queue reference model        |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conv_1st_sched;

  localparam int N_PIX = 40;
  localparam int DW    = 8;
  localparam int ROW_W = N_PIX * DW;
  typedef logic [ROW_W-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_1st_sched_if #(.N_PIX(N_PIX), .DW(DW)) bus ();

  conv_1st_sched #(.N_PIX(N_PIX), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: rows in issue order, plus counts of rows captured/drained.
  row_t exp_q[$];
  int   cap_cnt, drn_cnt, bidx, n_sta, n_done, cd, dp_lat, rdy_mode, frame_nch;
  bit   chk_en, in_frame, inj_valid, legit, prev_stall;
  logic [DW-1:0] prev_data;
  logic [5:0]    prev_idx;
  logic [4:0]    prev_ch;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    row_t cur;
    if (chk_en) begin
      chk("out_valid", bus.out_valid_o, 64'(cap_cnt > drn_cnt));
      chk("busy", bus.busy_o, 64'(in_frame));
      if (prev_stall) begin
        chk("stall_data", bus.out_data_o, prev_data);
        chk("stall_idx", bus.out_idx_o, prev_idx);
        chk("stall_ch", bus.out_ch_o, prev_ch);
      end
    end
    prev_stall = chk_en && bus.out_valid_o && !bus.out_ready_i;
    prev_data  = bus.out_data_o;
    prev_idx   = bus.out_idx_o;
    prev_ch    = bus.out_ch_o;
    if (bus.done_o) begin
      n_done++;
      chk("done_rows", 64'(drn_cnt), 64'(frame_nch));
      in_frame = 1'b0;
    end
    if (chk_en && bus.out_valid_o && bus.out_ready_i) begin
      chk("byte_queued", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        chk("byte_data", bus.out_data_o, cur[bidx*DW +: DW]);
        chk("byte_idx", bus.out_idx_o, 64'(bidx));
        chk("byte_ch", bus.out_ch_o, 64'(drn_cnt));
        chk("byte_last", bus.out_last_o, 64'(bidx == N_PIX - 1));
        if (bidx == N_PIX - 1) begin
          bidx = 0;
          drn_cnt++;
          void'(exp_q.pop_front());
        end else begin
          bidx++;
        end
      end
    end
    if (legit) cap_cnt++;
  endtask

  // One clock: drive datapath/sink just after the edge, check at the falling edge.
  task automatic tick();
    row_t row;
    @(posedge clk);
    #1;
    legit = 1'b0;
    bus.conv_valid_i = inj_valid;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        for (int w = 0; w < ROW_W / 32; w++) row[w*32 +: 32] = $urandom();
        bus.conv_data_i  = row;
        bus.conv_valid_i = 1'b1;
        legit            = 1'b1;
        exp_q.push_back(row);
      end
    end
    if (bus.conv_sta_o) begin
      n_sta++;
      cd = (dp_lat == 0) ? int'($urandom_range(1, 6)) : dp_lat;
    end
    case (rdy_mode)
      0:       bus.out_ready_i = 1'b1;
      1:       bus.out_ready_i = 1'b0;
      default: bus.out_ready_i = ($urandom_range(0, 9) < 7);
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; chk_en = 1'b0; cd = 0; inj_valid = 1'b0;
    repeat (cycles) tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_sta", bus.conv_sta_o, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_data", bus.out_data_o, 0);
    chk("rst_ch", bus.out_ch_o, 0);
    chk("rst_idx", bus.out_idx_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    rst = 1'b0;
    exp_q.delete(); cap_cnt = 0; drn_cnt = 0; bidx = 0; in_frame = 1'b0; chk_en = 1'b1;
  endtask

  task automatic start_frame(input logic [5:0] n);
    exp_q.delete(); cap_cnt = 0; drn_cnt = 0; bidx = 0; n_sta = 0; n_done = 0;
    frame_nch = (n == 6'd0 || n > 6'd32) ? 32 : int'(n);
    in_frame = 1'b1;
    bus.num_ch_i = n;
    bus.start_i  = 1'b1;
    tick();
    bus.start_i  = 1'b0;
    bus.num_ch_i = 6'($urandom());
    chk("first_sta", 64'(n_sta), 1);
  endtask

  task automatic run_frame(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("frame_done", 64'(n_done), 1);
    repeat (3) tick();
    chk("done_once", 64'(n_done), 1);
    chk("busy_after", bus.busy_o, 0);
    chk("rows_out", 64'(drn_cnt), 64'(frame_nch));
    chk("sta_total", 64'(n_sta), 64'(frame_nch));
    chk("err_clean", bus.err_o, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.num_ch_i = '0; bus.conv_valid_i = 1'b0;
    bus.conv_data_i = '0; bus.out_ready_i = 1'b0;
    cap_cnt = 0; drn_cnt = 0; bidx = 0; n_sta = 0; n_done = 0; cd = 0;
    dp_lat = 1; rdy_mode = 0; frame_nch = 0;
    chk_en = 1'b0; in_frame = 1'b0; inj_valid = 1'b0; legit = 1'b0; prev_stall = 1'b0;
    do_reset(3);

    // Single channel, slow datapath, always-ready sink
    dp_lat = 5; rdy_mode = 0;
    start_frame(6'd1);
    run_frame(400);

    // num_ch = 0 means 32 channels
    dp_lat = 1; rdy_mode = 0;
    start_frame(6'd0);
    run_frame(2000);

    // Long stall: at most two rows may be requested
    dp_lat = 2; rdy_mode = 1;
    start_frame(6'd4);
    repeat (200) tick();
    chk("stall_sta_le2", 64'(n_sta <= 2), 1);
    chk("stall_err", bus.err_o, 0);
    chk("stall_valid", bus.out_valid_o, 1);
    rdy_mode = 0;
    run_frame(600);

    // Unsolicited row in IDLE is sticky until the next start
    inj_valid = 1'b1; tick(); inj_valid = 1'b0; tick();
    chk("idle_err", bus.err_o, 1);
    repeat (5) tick();
    chk("idle_err_sticky", bus.err_o, 1);
    dp_lat = 2; rdy_mode = 2;
    start_frame(6'd2);
    chk("err_cleared", bus.err_o, 0);
    run_frame(800);

    // Reset mid-frame
    dp_lat = 3; rdy_mode = 2;
    start_frame(6'd4);
    k = 0;
    while (drn_cnt < 2 && k < 1000) begin
      tick();
      k++;
    end
    chk("reach_ch2", 64'(drn_cnt), 2);
    do_reset(1);
    chk("no_done_on_rst", 64'(n_done), 0);
    inj_valid = 1'b1; tick(); inj_valid = 1'b0; tick();
    chk("post_rst_err", bus.err_o, 1);
    start_frame(6'd3);
    run_frame(1000);

    // Random ready and latency over 8 channels, with a start while busy
    dp_lat = 0; rdy_mode = 2;
    start_frame(6'd8);
    repeat (100) tick();
    bus.start_i = 1'b1; bus.num_ch_i = 6'd1;
    repeat (3) tick();
    bus.start_i = 1'b0;
    run_frame(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
